pdm_decimador: RTL
==================

PDM_DECIMADOR -- requirements
Module: pdm_decimador

Interface
REQ-001 Parameter DEC_LOG2, default 6, log2 of the decimation ratio; legal range 5..8; ratio R = 2^DEC_LOG2.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous reset, active-high.
REQ-004 enable  input  1  when low, pdm_valid is ignored and no filter state changes.
REQ-005 pdm_bit  input  1  microphone PDM data bit (1 = +1, 0 = -1).
REQ-006 pdm_valid  input  1  one-cycle strobe; pdm_bit is accepted on a cycle where pdm_valid=1 and enable=1.
REQ-007 pcm_data  output  16  signed two's-complement PCM sample.
REQ-008 pcm_valid  output  1  pcm_data holds an unconsumed sample.
REQ-009 pcm_ready  input  1  consumer accepts the sample when pcm_valid=1 and pcm_ready=1.
REQ-010 overrun  output  1  sticky flag: a completed sample was dropped.
REQ-011 clr_ovr  input  1  one-cycle pulse that clears overrun.

Function
REQ-012 Filter: 3rd-order CIC, differential delay 1, decimation R; internal width W = 3*DEC_LOG2+2 bits, signed, two's-complement wrap-around in integrators and combs.
REQ-013 Input map: pdm_bit=1 -> +1, pdm_bit=0 -> -1, sign-extended to W.
REQ-014 Integrators: all three update only on the edge where a bit is accepted; I1+=x, I2+=I1(new), I3+=I2(new), chained within one cycle.
REQ-015 Decimation counter: counts accepted bits 0..R-1 and wraps to 0; the accepted bit where it equals R-1 raises an internal decimation strobe.
REQ-016 Comb stage, cycle after the strobe: C1 = I3 - I3_prev, C2 = C1 - C1_prev, C3 = C2 - C2_prev; the *_prev registers update only in this cycle.
REQ-017 Output scaling, cycle after the comb: y = C3 arithmetic-shifted right by (3*DEC_LOG2 - 15), saturated to [-32768, +32767].
REQ-018 Latency: pcm_valid rises exactly 2 clk cycles after the edge that accepted the R-th bit of a block.
REQ-019 First 2 output samples after reset are transient, are still delivered, and have no defined value.
REQ-020 Output buffer: a single register. A new sample loads if pcm_valid=0, or if pcm_valid=1 and pcm_ready=1 in the same cycle; in that case pcm_valid stays 1 and the old sample is consumed.
REQ-021 If a new sample completes while pcm_valid=1 and pcm_ready=0, the new sample is dropped, pcm_data is unchanged, and overrun is set to 1.
REQ-022 pcm_valid clears on an accept cycle with no new sample; pcm_data is held stable while pcm_valid=1 and not accepted.
REQ-023 overrun clears on clr_ovr=1; if a set and clr_ovr coincide, set wins.
REQ-024 enable low mid-block freezes the counter and integrators; the block resumes on re-enable without loss.
REQ-025 pdm_valid=1 with enable=0: no effect.

Reset
REQ-026 reset=1 at an edge clears integrators, combs, *_prev registers, decimation counter, and pipeline strobes to 0; pcm_data=0, pcm_valid=0, overrun=0.
REQ-027 Reset mid-block or mid-pipeline discards any partial or in-flight sample; no pcm_valid pulse follows reset.
REQ-028 reset takes priority over all other inputs.

Verification
REQ-029 DEC_LOG2=6, all-ones input with pdm_valid every 4th cycle and pcm_ready=1 -> from the 3rd sample on, pcm_data=32767 (saturated 32768).
REQ-030 All-zeros input -> from the 3rd sample on, pcm_data=-32768.
REQ-031 Alternating 1,0 input -> from the 3rd sample on, pcm_data=0; with 3-of-4 ones -> 16384.
REQ-032 pcm_ready=0 across two completed samples -> first sample held, overrun=1 after the second; clr_ovr -> overrun=0; ready+new sample in the same cycle -> no overrun, pcm_valid stays 1.
REQ-033 Latency check: pcm_valid rises exactly 2 cycles after the 64th accepted bit; toggling enable mid-block yields an identical sample sequence.
REQ-034 Assert reset during the comb cycle -> no pcm_valid, all outputs 0; the next full block yields a valid output 64 bits later.

Source files
------------

// File: rtl/pdm_decimador_if.sv
// pdm_decimador_if
// Purpose: bundles the PCM output handshake of the PDM decimator.
// Signals:
//   pcm_data  - 16-bit signed PCM sample (producer -> consumer)
//   pcm_valid - pcm_data holds an unconsumed sample (producer -> consumer)
//   pcm_ready - consumer accepts the sample when pcm_valid is high (consumer -> producer)
// Modports: master = sample producer (decimator), slave = sample consumer.
interface pdm_decimador_if;
    logic [15:0] pcm_data;
    logic        pcm_valid;
    logic        pcm_ready;

    modport master (
        output pcm_data,
        output pcm_valid,
        input  pcm_ready
    );

    modport slave (
        input  pcm_data,
        input  pcm_valid,
        output pcm_ready
    );
endinterface

// File: rtl/pdm_decimador.sv
// pdm_decimador
// Purpose: 3rd-order CIC decimator (differential delay 1, ratio 2^DEC_LOG2) turning a 1-bit
// PDM microphone stream into 16-bit signed PCM, with a single-entry output buffer and a
// sticky overrun flag for samples dropped while the buffer is full.
// Ports:
//   clk         - system clock, rising edge
//   reset       - synchronous reset, active high, overrides every other input
//   enable_i    - when low, PDM strobes are ignored and the filter state is frozen
//   pdm_bit_i   - PDM data bit (1 -> +1, 0 -> -1)
//   pdm_valid_i - one-cycle strobe qualifying pdm_bit_i
//   clr_ovr_i   - one-cycle pulse clearing overrun_o
//   overrun_o   - sticky: a completed sample was dropped
//   pcm_o       - PCM output handshake (data/valid out, ready in)
module pdm_decimador #(
    parameter int unsigned DEC_LOG2 = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable_i,
    input  logic             pdm_bit_i,
    input  logic             pdm_valid_i,
    input  logic             clr_ovr_i,
    output logic             overrun_o,
    pdm_decimador_if.master  pcm_o
);

    localparam int unsigned W     = 3 * DEC_LOG2 + 2;
    localparam int unsigned Shift = 3 * DEC_LOG2 - 15;

    localparam logic [DEC_LOG2-1:0] CntLast = '1;
    localparam logic signed [W-1:0] PosMax  = W'(32767);
    localparam logic signed [W-1:0] NegMin  = W'(-32768);

    // Integrator, comb and pipeline state
    logic signed [W-1:0]  i1_q, i2_q, i3_q;
    logic signed [W-1:0]  i1_d, i2_d, i3_d;
    logic signed [W-1:0]  i3_prev_q, c1_prev_q, c2_prev_q, c3_q;
    logic signed [W-1:0]  c1, c2, c3;
    logic [DEC_LOG2-1:0]  cnt_q;
    logic                 dec_stb_q, comb_stb_q;

    // Output buffer
    logic [15:0]          pcm_data_q, pcm_data_d;
    logic                 pcm_valid_q, pcm_valid_d;
    logic                 overrun_q, overrun_d;

    logic                 accept;
    logic signed [W-1:0]  x;
    logic signed [W-1:0]  y_shift;
    logic signed [15:0]   y_sat;
    logic                 consume;
    logic                 ovr_set;

    assign accept = enable_i & pdm_valid_i;

    // Integrators chain within one cycle: each stage adds the freshly updated previous stage
    always_comb begin
        x    = pdm_bit_i ? W'(1) : '1;
        i1_d = i1_q + x;
        i2_d = i2_q + i1_d;
        i3_d = i3_q + i2_d;
    end

    // Combs run on the registered integrator output in the cycle after the decimation strobe
    always_comb begin
        c1 = i3_q - i3_prev_q;
        c2 = c1 - c1_prev_q;
        c3 = c2 - c2_prev_q;
    end

    // Scale the full-gain CIC result down to 16 bits, saturating the +R^3 corner case
    always_comb begin
        y_shift = c3_q >>> Shift;
        if (y_shift > PosMax) begin
            y_sat = 16'sh7fff;
        end else if (y_shift < NegMin) begin
            y_sat = 16'sh8000;
        end else begin
            y_sat = y_shift[15:0];
        end
    end

    // Single-entry buffer: a new sample may replace one consumed in the same cycle,
    // otherwise it is dropped and flagged
    always_comb begin
        pcm_data_d  = pcm_data_q;
        pcm_valid_d = pcm_valid_q;
        consume     = pcm_valid_q & pcm_o.pcm_ready;
        ovr_set     = 1'b0;
        if (comb_stb_q) begin
            if (!pcm_valid_q || consume) begin
                pcm_data_d  = y_sat;
                pcm_valid_d = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (consume) begin
            pcm_valid_d = 1'b0;
        end
        // Set beats clear when both happen in the same cycle
        if (ovr_set) begin
            overrun_d = 1'b1;
        end else if (clr_ovr_i) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            i1_q        <= '0;
            i2_q        <= '0;
            i3_q        <= '0;
            i3_prev_q   <= '0;
            c1_prev_q   <= '0;
            c2_prev_q   <= '0;
            c3_q        <= '0;
            cnt_q       <= '0;
            dec_stb_q   <= 1'b0;
            comb_stb_q  <= 1'b0;
            pcm_data_q  <= '0;
            pcm_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (accept) begin
                i1_q  <= i1_d;
                i2_q  <= i2_d;
                i3_q  <= i3_d;
                cnt_q <= cnt_q + 1'b1;
            end
            dec_stb_q  <= accept && (cnt_q == CntLast);
            comb_stb_q <= dec_stb_q;
            if (dec_stb_q) begin
                i3_prev_q <= i3_q;
                c1_prev_q <= c1;
                c2_prev_q <= c2;
                c3_q      <= c3;
            end
            pcm_data_q  <= pcm_data_d;
            pcm_valid_q <= pcm_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign pcm_o.pcm_data  = pcm_data_q;
    assign pcm_o.pcm_valid = pcm_valid_q;
    assign overrun_o       = overrun_q;

endmodule
